// File: rtl/adc_source_pkg.sv
// Shared types and channel codes for the ADC sample source selector.
package adc_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BYTE = 2'd1,
        ST_DONE      = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [7:0] CH_GEN1 = 8'h01;
    localparam logic [7:0] CH_GEN2 = 8'h02;
    localparam logic [7:0] CH_GEN3 = 8'h03;
    localparam logic [7:0] CH_EXT  = 8'h04;

endpackage

// File: rtl/adc_source_select_tri_wave_gen.sv
// Triangle-wave test generator: saturating ramp over 0..2^WIDTH-1 that
// reverses direction at either end, advancing once per step pulse.
module tri_wave_gen
    import adc_source_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned INC   = 1,
    parameter int unsigned DEC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam int unsigned      SUM_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX   = '1;

    logic [WIDTH-1:0] value_q, value_d;
    dir_e             dir_q, dir_d;
    logic [SUM_W-1:0] sum_up;

    assign sum_up = {1'b0, value_q} + SUM_W'(INC);
    assign value  = value_q;

    // Next value: clamp to the rail and flip direction when a step would overshoot
    always_comb begin
        value_d = value_q;
        dir_d   = dir_q;
        if (step) begin
            if (dir_q == DIR_UP) begin
                if (sum_up >= {1'b0, MAX}) begin
                    value_d = MAX;
                    dir_d   = DIR_DOWN;
                end else begin
                    value_d = sum_up[WIDTH-1:0];
                end
            end else begin
                if (value_q <= WIDTH'(DEC)) begin
                    value_d = '0;
                    dir_d   = DIR_UP;
                end else begin
                    value_d = value_q - WIDTH'(DEC);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            dir_q   <= DIR_UP;
        end else begin
            value_q <= value_d;
            dir_q   <= dir_d;
        end
    end

    // A zero step would freeze the wave at one rail
    step_nonzero_a: assert property (@(posedge clk) disable iff (rst) (INC != 0) && (DEC != 0));

endmodule

// File: rtl/adc_source_select.sv
// Sample source selector: UART-configured choice of three triangle generators,
// plus an external ADC input when ADC_SEL_EXT_EN is defined.
module adc_source_select
    import adc_source_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned INC1  = 1,
    parameter int unsigned DEC1  = 1,
    parameter int unsigned INC2  = 5,
    parameter int unsigned DEC2  = 5,
    parameter int unsigned INC3  = 1,
    parameter int unsigned DEC3  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             activate,
    output logic             done,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             sample_en,
`ifdef ADC_SEL_EXT_EN
    input  logic [WIDTH-1:0] ext_adc_data,
`endif
    output logic [WIDTH-1:0] adc_data,
    output logic             adc_strobe
);

    state_e           state_q, state_d;
    logic [7:0]       sel_q, sel_d;
    logic             done_q, done_d;
    logic             strobe_q;
    logic [WIDTH-1:0] gen1_val, gen2_val, gen3_val;

    // Channel-select FSM; the activating command byte is never taken as a channel code
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (activate) state_d = ST_WAIT_BYTE;
            end
            ST_WAIT_BYTE: begin
                if (rx_ready) begin
                    state_d = ST_DONE;
                    case (rx_data)
                        CH_GEN1, CH_GEN2, CH_GEN3: sel_d = rx_data;
`ifdef ADC_SEL_EXT_EN
                        CH_EXT:                    sel_d = rx_data;
`endif
                        default:                   sel_d = sel_q;
                    endcase
                end else if (!activate) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!activate) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= CH_GEN1;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            strobe_q <= sample_en;
        end
    end

    assign done       = done_q;
    assign adc_strobe = strobe_q;

    tri_wave_gen #(.WIDTH(WIDTH), .INC(INC1), .DEC(DEC1)) u_gen1 (
        .clk   (clk),
        .rst   (rst),
        .step  (sample_en && (sel_q == CH_GEN1)),
        .value (gen1_val)
    );

    tri_wave_gen #(.WIDTH(WIDTH), .INC(INC2), .DEC(DEC2)) u_gen2 (
        .clk   (clk),
        .rst   (rst),
        .step  (sample_en && (sel_q == CH_GEN2)),
        .value (gen2_val)
    );

    tri_wave_gen #(.WIDTH(WIDTH), .INC(INC3), .DEC(DEC3)) u_gen3 (
        .clk   (clk),
        .rst   (rst),
        .step  (sample_en && (sel_q == CH_GEN3)),
        .value (gen3_val)
    );

    always_comb begin
        case (sel_q)
            CH_GEN2: adc_data = gen2_val;
            CH_GEN3: adc_data = gen3_val;
`ifdef ADC_SEL_EXT_EN
            CH_EXT:  adc_data = ext_adc_data;
`endif
            default: adc_data = gen1_val;
        endcase
    end

endmodule

// File: tb/tb_adc_source_select.sv
// Scoreboard bench for adc_source_select; build with +define+ADC_SEL_EXT_EN
// to also cover the external channel.
module tb_adc_source_select;

    logic       clk;
    logic       rst;
    logic       activate;
    logic       done;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       sample_en;
    logic [7:0] adc_data;
    logic       adc_strobe;
`ifdef ADC_SEL_EXT_EN
    logic [7:0] ext_adc_data;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    adc_source_select dut (
        .clk          (clk),
        .rst          (rst),
        .activate     (activate),
        .done         (done),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .sample_en    (sample_en),
`ifdef ADC_SEL_EXT_EN
        .ext_adc_data (ext_adc_data),
`endif
        .adc_data     (adc_data),
        .adc_strobe   (adc_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobed sample is compared against the next queued expectation
    always @(negedge clk) begin
        if (!rst && adc_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got data %0h with empty queue", adc_data);
            end else begin
                check("sample", 32'(adc_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] exp);
        exp_q.push_back(exp);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic select(input logic [7:0] code);
        activate = 1'b1;
        tick();
        check("done_wait", 32'(done), 32'd0);
        rx_data  = code;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("done_set", 32'(done), 32'd1);
        activate = 1'b0;
        tick();
        check("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; activate = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; sample_en = 1'b0;
`ifdef ADC_SEL_EXT_EN
        ext_adc_data = 8'h00;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_data", 32'(adc_data), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_strobe", 32'(adc_strobe), 32'd0);

        // Generator 1 by default
        pulse(8'd1); pulse(8'd2); pulse(8'd3);
        tick();
        check("gen1_done_low", 32'(done), 32'd0);

        // Generator 2: ramp to the top rail and turn around
        select(8'h02);
        for (int i = 1; i <= 50; i++) pulse(8'(5 * i));
        pulse(8'd255);
        pulse(8'd250);
        tick();

        // Generator 3 for 10 samples, then generator 1 resumes from its held value
        select(8'h03);
        for (int i = 1; i <= 10; i++) pulse(8'(i));
        tick();
        select(8'h01);
        check("gen1_held", 32'(adc_data), 32'd3);
        pulse(8'd4); pulse(8'd5);
        tick();

        // Invalid code keeps the current selection
        select(8'h02);
        select(8'h7F);
        check("invalid_keeps_gen2", 32'(adc_data), 32'd250);
        pulse(8'd245);
        tick();
`ifndef ADC_SEL_EXT_EN
        select(8'h04);
        check("ext_code_invalid", 32'(adc_data), 32'd245);
`endif

        // Generator 3 was frozen while unselected
        select(8'h03);
        check("gen3_frozen", 32'(adc_data), 32'd10);
        pulse(8'd11);
        tick();

`ifdef ADC_SEL_EXT_EN
        ext_adc_data = 8'hA5;
        select(8'h04);
        check("ext_data", 32'(adc_data), 32'hA5);
        pulse(8'hA5);
        tick();
`endif

        // Reset while waiting for the channel byte
        activate = 1'b1;
        tick();
        rst = 1'b1;
        activate = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_data", 32'(adc_data), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        rx_data  = 8'h02;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        check("stray_rx_done", 32'(done), 32'd0);
        pulse(8'd1);
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
